// File: rtl/otter_dport_arbiter.sv
// otter_dport_arbiter: shares OTTER memory port 2 between the CPU MEM stage
// and a secondary bus master (DMA). One access per cycle, CPU priority with
// DMA anti-starvation, short locked DMA bursts, and one-cycle read return
// steered back to whichever requester issued the load.
module otter_dport_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int BURST_MAX    = 4,
   parameter int CNT_W        = 4
) (
   input  logic        MEM_CLK,
   input  logic        MEM_RST_N,
   // CPU (pipeline MEM stage)
   input  logic        CPU_REQ,
   input  logic        CPU_WE,
   input  logic [31:0] CPU_ADDR,
   input  logic [31:0] CPU_DIN,
   input  logic [1:0]  CPU_SIZE,
   input  logic        CPU_SIGN,
   output logic        CPU_GNT,
   output logic        CPU_STALL,
   output logic        CPU_RVALID,
   output logic [31:0] CPU_RDATA,
   // DMA / debug loader
   input  logic        DMA_REQ,
   input  logic        DMA_WE,
   input  logic [31:0] DMA_ADDR,
   input  logic [31:0] DMA_DIN,
   input  logic [1:0]  DMA_SIZE,
   input  logic        DMA_SIGN,
   input  logic        DMA_LOCK,
   output logic        DMA_GNT,
   output logic        DMA_RVALID,
   output logic [31:0] DMA_RDATA,
   // memory port 2
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);

   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t            r_state, w_next_state;
   logic [CNT_W-1:0]  r_starve_cnt, r_burst_cnt;
   logic              r_cpu_pri;      // CPU wins the cycle right after a burst ends
   logic              r_rd_vld, r_rd_owner;
   logic [31:0]       r_addr, r_din;
   logic [1:0]        r_size;
   logic              r_sign;
   logic [31:0]       r_cpu_rdata, r_dma_rdata;

   logic              w_cpu_gnt, w_dma_gnt, w_any, w_burst_exit;
   logic              w_sel_we, w_sel_sign;
   logic [31:0]       w_sel_addr, w_sel_din;
   logic [1:0]        w_sel_size;

   // Grant decision and next state; grants are suppressed while in reset
   always_comb begin
      w_cpu_gnt    = 1'b0;
      w_dma_gnt    = 1'b0;
      w_burst_exit = 1'b0;
      w_next_state = r_state;
      if (MEM_RST_N) begin
         case (r_state)
            S_IDLE: begin
               if (CPU_REQ && DMA_REQ) begin
                  if (r_cpu_pri || (r_starve_cnt < STARVE_MAX)) w_cpu_gnt = 1'b1;
                  else                                          w_dma_gnt = 1'b1;
               end else begin
                  w_cpu_gnt = CPU_REQ;
                  w_dma_gnt = DMA_REQ;
               end
               if (w_dma_gnt && DMA_LOCK) w_next_state = S_BURST;
            end
            S_BURST: begin
               w_dma_gnt = DMA_REQ;
               // the exit beat is still granted; burst_cnt reaching the max ends it
               if (!DMA_REQ || !DMA_LOCK || (r_burst_cnt == BURST_LAST)) begin
                  w_next_state = S_IDLE;
                  w_burst_exit = 1'b1;
               end
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // State, starvation and burst bookkeeping
   always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
      if (!MEM_RST_N) begin
         r_state      <= S_IDLE;
         r_starve_cnt <= '0;
         r_burst_cnt  <= '0;
         r_cpu_pri    <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_cpu_pri <= w_burst_exit;
         if (r_state == S_IDLE && w_next_state == S_BURST) r_burst_cnt <= CNT_W'(1);
         else if (r_state == S_BURST && w_dma_gnt)         r_burst_cnt <= r_burst_cnt + 1'b1;
         if (w_dma_gnt || !DMA_REQ)           r_starve_cnt <= '0;
         else if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   // Winner mux toward memory
   always_comb begin
      w_any      = w_cpu_gnt | w_dma_gnt;
      w_sel_we   = w_dma_gnt ? DMA_WE   : CPU_WE;
      w_sel_addr = w_dma_gnt ? DMA_ADDR : CPU_ADDR;
      w_sel_din  = w_dma_gnt ? DMA_DIN  : CPU_DIN;
      w_sel_size = w_dma_gnt ? DMA_SIZE : CPU_SIZE;
      w_sel_sign = w_dma_gnt ? DMA_SIGN : CPU_SIGN;
   end

   // Remember the last issued address/data so idle cycles hold them
   always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
      if (!MEM_RST_N) begin
         r_addr <= '0;
         r_din  <= '0;
         r_size <= '0;
         r_sign <= 1'b0;
      end else if (w_any) begin
         r_addr <= w_sel_addr;
         r_din  <= w_sel_din;
         r_size <= w_sel_size;
         r_sign <= w_sel_sign;
      end
   end

   // Track who owns the read data arriving next cycle, and hold each side's last data
   always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
      if (!MEM_RST_N) begin
         r_rd_vld    <= 1'b0;
         r_rd_owner  <= 1'b0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_rd_vld   <= w_any & ~w_sel_we;
         r_rd_owner <= w_dma_gnt;
         if (CPU_RVALID) r_cpu_rdata <= MEM_DOUT2;
         if (DMA_RVALID) r_dma_rdata <= MEM_DOUT2;
      end
   end

   assign CPU_GNT    = w_cpu_gnt;
   assign DMA_GNT    = w_dma_gnt;
   assign CPU_STALL  = CPU_REQ & ~w_cpu_gnt;
   assign MEM_READ2  = w_any & ~w_sel_we;
   assign MEM_WRITE2 = w_any &  w_sel_we;
   assign MEM_ADDR2  = w_any ? w_sel_addr : r_addr;
   assign MEM_DIN2   = w_any ? w_sel_din  : r_din;
   assign MEM_SIZE   = w_any ? w_sel_size : r_size;
   assign MEM_SIGN   = w_any ? w_sel_sign : r_sign;
   assign CPU_RVALID = r_rd_vld & ~r_rd_owner;
   assign DMA_RVALID = r_rd_vld &  r_rd_owner;
   assign CPU_RDATA  = CPU_RVALID ? MEM_DOUT2 : r_cpu_rdata;
   assign DMA_RDATA  = DMA_RVALID ? MEM_DOUT2 : r_dma_rdata;

endmodule

// File: tb/tb_otter_dport_arbiter.sv
// Bench for otter_dport_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_otter_dport_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_sign, dma_req, dma_we, dma_sign, dma_lock;
   logic [31:0] cpu_addr, cpu_din, dma_addr, dma_din;
   logic [1:0]  cpu_size, dma_size;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [31:0] cpu_rdata, dma_rdata;
   logic [31:0] mem_addr2, mem_din2, mem_dout2;
   logic        mem_write2, mem_read2, mem_sign;
   logic [1:0]  mem_size;

   int n_checks = 0;
   int n_fail   = 0;

   otter_dport_arbiter #(.STARVE_LIMIT(8), .BURST_MAX(4), .CNT_W(4)) dut (
      .MEM_CLK(clk), .MEM_RST_N(rst_n),
      .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din),
      .CPU_SIZE(cpu_size), .CPU_SIGN(cpu_sign), .CPU_GNT(cpu_gnt), .CPU_STALL(cpu_stall),
      .CPU_RVALID(cpu_rvalid), .CPU_RDATA(cpu_rdata),
      .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr), .DMA_DIN(dma_din),
      .DMA_SIZE(dma_size), .DMA_SIGN(dma_sign), .DMA_LOCK(dma_lock), .DMA_GNT(dma_gnt),
      .DMA_RVALID(dma_rvalid), .DMA_RDATA(dma_rdata),
      .MEM_ADDR2(mem_addr2), .MEM_DIN2(mem_din2), .MEM_WRITE2(mem_write2),
      .MEM_READ2(mem_read2), .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout2)
   );

   always #5 clk = ~clk;

   // read-only memory image: fixed word at 0x100, hashed contents elsewhere
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   always @(posedge clk) if (mem_read2) mem_dout2 <= memf(mem_addr2);

   task automatic clr();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0; cpu_size = 2; cpu_sign = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_din = 0; dma_size = 2; dma_sign = 0;
      dma_lock = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin @(negedge clk); clr(); end
   endtask

   task automatic test_reset();
      clr(); rst_n = 0;
      @(negedge clk); #1;
      n_checks++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write2, mem_read2} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl got %b want 000000",
            {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write2, mem_read2});
      end
      n_checks++;
      if ({mem_addr2, mem_din2, mem_size, mem_sign, cpu_rdata, dma_rdata} !== '0) begin
         n_fail++; $display("FAIL reset_data addr=%h din=%h crd=%h drd=%h want 0",
            mem_addr2, mem_din2, cpu_rdata, dma_rdata);
      end
      @(negedge clk); rst_n = 1;
      idle(2);
   endtask

   task automatic test_cpu_load();
      @(negedge clk); clr(); cpu_req = 1; cpu_addr = 32'h100; #1;
      n_checks++;
      if ({cpu_gnt, cpu_stall, mem_read2, mem_write2} !== 4'b1010 || mem_addr2 !== 32'h100) begin
         n_fail++; $display("FAIL cpu_load_issue gnt/stall/rd/wr=%b addr=%h want 1010 100",
            {cpu_gnt, cpu_stall, mem_read2, mem_write2}, mem_addr2);
      end
      @(negedge clk); clr(); #1;
      n_checks++;
      if (cpu_rvalid !== 1 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 0) begin
         n_fail++; $display("FAIL cpu_load_return rv=%b data=%h drv=%b want 1 deadbeef 0",
            cpu_rvalid, cpu_rdata, dma_rvalid);
      end
      idle(2);
   endtask

   task automatic test_starvation();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); clr();
         cpu_req = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h20; #1;
         n_checks++;
         if (k == 8) begin
            if (dma_gnt !== 1 || cpu_gnt !== 0 || cpu_stall !== 1 || mem_addr2 !== 32'h20) begin
               n_fail++; $display("FAIL starve_dma_win k=%0d dgnt=%b cgnt=%b stall=%b want 1 0 1",
                  k, dma_gnt, cpu_gnt, cpu_stall);
            end
         end else begin
            if (cpu_gnt !== 1 || dma_gnt !== 0 || cpu_stall !== 0) begin
               n_fail++; $display("FAIL starve_cpu_win k=%0d cgnt=%b dgnt=%b want 1 0",
                  k, cpu_gnt, dma_gnt);
            end
         end
         n_checks++;
         if (cpu_rvalid && dma_rvalid) begin
            n_fail++; $display("FAIL starve_rvalid_both k=%0d got 11 want at most one", k);
         end
      end
      idle(2);
   endtask

   task automatic test_burst();
      // expected winner per cycle: 0..3 DMA burst, 4 CPU, 5..6 DMA resumes
      logic [6:0] exp_d;
      exp_d = 7'b1101111;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); clr();
         dma_req = 1; dma_we = 1; dma_lock = 1;
         dma_addr = 32'h300 + 32'(k < 4 ? k : k - 1) * 4;
         dma_din = 32'hA000 + 32'(k);
         cpu_req = (k >= 1 && k <= 4); cpu_addr = 32'h40;
         #1;
         n_checks++;
         if (dma_gnt !== exp_d[k] || cpu_gnt !== (cpu_req & ~exp_d[k])) begin
            n_fail++; $display("FAIL burst_gnt k=%0d dgnt=%b cgnt=%b want %b %b",
               k, dma_gnt, cpu_gnt, exp_d[k], cpu_req & ~exp_d[k]);
         end
         if (exp_d[k]) begin
            n_checks++;
            if (mem_write2 !== 1 || mem_din2 !== dma_din || mem_addr2 !== dma_addr) begin
               n_fail++; $display("FAIL burst_write k=%0d wr=%b din=%h addr=%h want 1 %h %h",
                  k, mem_write2, mem_din2, mem_addr2, dma_din, dma_addr);
            end
         end
      end
      idle(3);
   endtask

   task automatic test_alternate();
      @(negedge clk); clr(); cpu_req = 1; cpu_addr = 32'h10;
      @(negedge clk); clr(); dma_req = 1; dma_addr = 32'h20; #1;
      n_checks++;
      if (cpu_rvalid !== 1 || dma_rvalid !== 0 || cpu_rdata !== memf(32'h10) || dma_gnt !== 1) begin
         n_fail++; $display("FAIL alt_cpu_ret crv=%b drv=%b data=%h dgnt=%b want 1 0 %h 1",
            cpu_rvalid, dma_rvalid, cpu_rdata, dma_gnt, memf(32'h10));
      end
      @(negedge clk); clr(); #1;
      n_checks++;
      if (dma_rvalid !== 1 || cpu_rvalid !== 0 || dma_rdata !== memf(32'h20)
          || cpu_rdata !== memf(32'h10)) begin
         n_fail++; $display("FAIL alt_dma_ret drv=%b crv=%b data=%h chold=%h want 1 0 %h %h",
            dma_rvalid, cpu_rvalid, dma_rdata, cpu_rdata, memf(32'h20), memf(32'h10));
      end
      idle(2);
   endtask

   task automatic test_store_byte();
      @(negedge clk); clr();
      dma_req = 1; dma_we = 1; dma_addr = 32'h203; dma_din = 32'hAB; dma_size = 0; #1;
      n_checks++;
      if ({mem_write2, mem_read2} !== 2'b10 || mem_size !== 2'd0 || mem_addr2 !== 32'h203
          || mem_din2 !== 32'hAB) begin
         n_fail++; $display("FAIL sb_issue wr/rd=%b size=%0d addr=%h din=%h want 10 0 203 ab",
            {mem_write2, mem_read2}, mem_size, mem_addr2, mem_din2);
      end
      @(negedge clk); clr(); #1;
      n_checks++;
      if (cpu_rvalid !== 0 || dma_rvalid !== 0 || mem_addr2 !== 32'h203 || mem_write2 !== 0) begin
         n_fail++; $display("FAIL sb_after rv=%b%b addr=%h wr=%b want 00 203 0",
            cpu_rvalid, dma_rvalid, mem_addr2, mem_write2);
      end
      idle(2);
   endtask

   task automatic test_reset_midop();
      @(negedge clk); clr(); cpu_req = 1; cpu_addr = 32'h40;
      @(negedge clk); clr(); rst_n = 0; #1;
      n_checks++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write2, mem_read2, cpu_stall} !== 7'b0
          || {mem_addr2, mem_din2, mem_size, mem_sign, cpu_rdata, dma_rdata} !== '0) begin
         n_fail++; $display("FAIL midrst_zero ctrl=%b addr=%h crd=%h want all 0",
            {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_write2, mem_read2, cpu_stall},
            mem_addr2, cpu_rdata);
      end
      @(negedge clk); cpu_req = 1; cpu_addr = 32'h44; #1;
      n_checks++;
      if (cpu_gnt !== 0 || mem_read2 !== 0) begin
         n_fail++; $display("FAIL midrst_gnt gnt=%b rd=%b want 0 0", cpu_gnt, mem_read2);
      end
      @(negedge clk); rst_n = 1; #1;
      n_checks++;
      if (cpu_gnt !== 1 || mem_addr2 !== 32'h44 || cpu_rvalid !== 0) begin
         n_fail++; $display("FAIL midrst_resume gnt=%b addr=%h rv=%b want 1 44 0",
            cpu_gnt, mem_addr2, cpu_rvalid);
      end
      @(negedge clk); clr(); #1;
      n_checks++;
      if (cpu_rvalid !== 1 || cpu_rdata !== memf(32'h44)) begin
         n_fail++; $display("FAIL midrst_ret rv=%b data=%h want 1 %h", cpu_rvalid, cpu_rdata,
            memf(32'h44));
      end
      idle(2);
   endtask

   task automatic test_random();
      int          starve, beats;
      bit          in_burst, cpu_first, pv, powner, ec, ed, c_hold, d_hold, nwe;
      logic [31:0] pdata, l_addr, l_din, c_last, d_last, e_addr;
      // start from a clean reset so held values are known
      @(negedge clk); clr(); rst_n = 0;
      @(negedge clk); rst_n = 1;
      starve = 0; beats = 0; in_burst = 0; cpu_first = 0; pv = 0; powner = 0; pdata = 0;
      l_addr = 0; l_din = 0; c_last = 0; d_last = 0; c_hold = 0; d_hold = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (!c_hold) begin
            cpu_req = ($urandom % 3) != 0; cpu_we = $urandom % 2; cpu_din = $urandom;
            cpu_size = 2'($urandom % 3); cpu_sign = $urandom % 2;
            cpu_addr = cpu_we ? 32'h200 + ($urandom % 128) * 4 : ($urandom % 128) * 4;
         end
         if (!d_hold) begin
            dma_req = $urandom % 2; dma_we = $urandom % 2; dma_din = $urandom;
            dma_size = 2'($urandom % 3); dma_sign = $urandom % 2;
            dma_addr = dma_we ? 32'h200 + ($urandom % 128) * 4 : ($urandom % 128) * 4;
         end
         dma_lock = ($urandom % 4) != 0;
         #1;
         // expected winner from the arbitration rules
         if (in_burst) begin ec = 0; ed = dma_req; end
         else if (cpu_req && dma_req) begin
            ec = cpu_first || starve < 8; ed = !ec;
         end else begin ec = cpu_req; ed = dma_req; end
         e_addr = ed ? dma_addr : ec ? cpu_addr : l_addr;
         nwe    = ed ? dma_we : cpu_we;
         n_checks++;
         if (cpu_gnt !== ec || dma_gnt !== ed || cpu_stall !== (cpu_req & ~ec)) begin
            n_fail++; $display("FAIL rnd_gnt cyc=%0d c/d/stall=%b%b%b want %b%b%b", cyc,
               cpu_gnt, dma_gnt, cpu_stall, ec, ed, cpu_req & ~ec);
         end
         n_checks++;
         if (mem_read2 !== ((ec | ed) & ~nwe) || mem_write2 !== ((ec | ed) & nwe)
             || mem_addr2 !== e_addr) begin
            n_fail++; $display("FAIL rnd_mem cyc=%0d rd=%b wr=%b addr=%h want %b %b %h", cyc,
               mem_read2, mem_write2, mem_addr2, (ec | ed) & ~nwe, (ec | ed) & nwe, e_addr);
         end
         n_checks++;
         if (cpu_rvalid !== (pv & ~powner) || dma_rvalid !== (pv & powner)
             || cpu_rdata !== ((pv & ~powner) ? pdata : c_last)
             || dma_rdata !== ((pv & powner) ? pdata : d_last)) begin
            n_fail++; $display("FAIL rnd_ret cyc=%0d rv=%b%b crd=%h drd=%h want %b%b %h %h", cyc,
               cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, pv & ~powner, pv & powner,
               (pv & ~powner) ? pdata : c_last, (pv & powner) ? pdata : d_last);
         end
         // advance the model
         if (pv && !powner) c_last = pdata;
         if (pv && powner)  d_last = pdata;
         pv = (ec | ed) & ~nwe; powner = ed; pdata = memf(e_addr);
         if (ec | ed) begin l_addr = e_addr; l_din = ed ? dma_din : cpu_din; end
         cpu_first = 0;
         if (in_burst) begin
            if (!dma_req) begin in_burst = 0; cpu_first = 1; end
            else begin
               beats++;
               if (!dma_lock || beats == 4) begin in_burst = 0; cpu_first = 1; end
            end
         end else if (ed && dma_lock) begin in_burst = 1; beats = 1; end
         if (ed || !dma_req) starve = 0;
         else if (starve < 8) starve++;
         c_hold = cpu_req && !ec;
         d_hold = dma_req && !ed;
      end
      idle(2);
   endtask

   initial begin
      clr(); rst_n = 0;
      test_reset();
      test_cpu_load();
      test_starvation();
      test_burst();
      test_alternate();
      test_store_byte();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/otter_dport_arbiter.md
Name: otter_dport_arbiter

Overview:
- Arbitrates the data port (port 2) of the OTTER byte-addressable dual-port memory between two requesters: the pipeline MEM stage (CPU) and a secondary bus master (DMA/debug loader).
- Issues at most one access per cycle to the memory, then routes the one-cycle-late read data back to the requester that issued it.
- Drives the CPU stall when the CPU loses arbitration. Enforces anti-starvation for the DMA and supports short locked DMA bursts.
- Sits between the pipeline/DMA and the memory port 2 signals (address, write data, write, read, size, sign, read data).

Parameters:
- STARVE_LIMIT, 8: consecutive cycles a pending DMA request may lose to the CPU before it is forced to win.
- BURST_MAX, 4: maximum beats in one locked DMA burst.
- CNT_W, 4: width of the starvation and burst counters; must hold max(STARVE_LIMIT, BURST_MAX).

Ports:
- MEM_CLK  in  1  clock; all state updates on the rising edge.
- MEM_RST_N  in  1  reset, asynchronous assert, active-low.
- CPU_REQ  in  1  CPU access request; address, data and controls held stable until CPU_GNT.
- CPU_WE  in  1  1 = store, 0 = load.
- CPU_ADDR  in  32  byte address.
- CPU_DIN  in  32  store data.
- CPU_SIZE  in  2  0 = byte, 1 = half, 2 = word.
- CPU_SIGN  in  1  1 = unsigned load.
- CPU_GNT  out  1  access issued this cycle.
- CPU_STALL  out  1  equals CPU_REQ & ~CPU_GNT.
- CPU_RVALID  out  1  CPU_RDATA is valid this cycle.
- CPU_RDATA  out  32  load data.
- DMA_REQ, DMA_WE, DMA_ADDR, DMA_DIN, DMA_SIZE, DMA_SIGN  in  1/1/32/32/2/1  same meaning as the CPU group.
- DMA_LOCK  in  1  request to keep the grant for the following beat.
- DMA_GNT  out  1  access issued this cycle.
- DMA_RVALID  out  1  DMA_RDATA is valid this cycle.
- DMA_RDATA  out  32  load data.
- MEM_ADDR2  out  32  to memory.
- MEM_DIN2  out  32  to memory.
- MEM_WRITE2  out  1  to memory.
- MEM_READ2  out  1  to memory.
- MEM_SIZE  out  2  to memory.
- MEM_SIGN  out  1  to memory.
- MEM_DOUT2  in  32  from memory; valid one cycle after MEM_READ2.

Behaviour:
- Reset (async, MEM_RST_N = 0):
  - State = IDLE; starve_cnt = 0; burst_cnt = 0; rd_owner_vld = 0.
  - All GNT, RVALID, MEM_WRITE2 and MEM_READ2 outputs = 0.
  - MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN = 0.
  - RDATA outputs = 0.
- Reset mid-operation: any pending read return is dropped, so no RVALID follows. A memory write already clocked in is not undone.
- States:
  - IDLE: CPU has priority.
  - DMA_BURST: DMA holds the port.
- Grant decision in IDLE (combinational, same cycle as the request):
  - Only one requester: that requester wins.
  - Both requesting and starve_cnt < STARVE_LIMIT: CPU wins.
  - Both requesting and starve_cnt == STARVE_LIMIT: DMA wins.
- starve_cnt:
  - Increments when DMA_REQ is high and DMA loses; saturates at STARVE_LIMIT.
  - Clears to 0 on DMA_GNT, or when DMA_REQ is low.
- DMA_BURST entry: taken when DMA wins in IDLE with DMA_LOCK = 1. burst_cnt is set to 1.
- DMA_BURST behaviour:
  - DMA wins every cycle DMA_REQ is high. CPU_GNT = 0.
  - burst_cnt increments on each DMA_GNT.
  - Exit to IDLE on any of: DMA_LOCK = 0 at a granted beat; DMA_REQ = 0; burst_cnt reaching BURST_MAX at a granted beat.
  - The exit beat itself is still granted.
  - After exit, if both requesters are pending, the CPU wins the next cycle regardless of starve_cnt.
- Memory drive:
  - MEM_* outputs are a combinational mux of the winner's signals.
  - MEM_READ2 = grant & ~WE; MEM_WRITE2 = grant & WE.
  - With no grant, MEM_READ2 = MEM_WRITE2 = 0 and the address/data outputs hold their last value.
- Read return:
  - On a granted load, register rd_owner (0 = CPU, 1 = DMA) and set rd_owner_vld = 1.
  - Next cycle, the owner's RVALID = 1 and its RDATA = MEM_DOUT2 (combinational pass-through). The other requester's RDATA holds its last value.
  - Back-to-back loads give one RVALID per cycle, in issue order.
- Writes produce no RVALID; GNT is the completion.
- Address, size and sign are forwarded unchanged; alignment and IO-range decode are left to the memory.
- Throughput: one access per cycle. Latency is 0 cycles request-to-grant and 1 cycle grant-to-data.

Test Plan:
- CPU-only load of address 0x100, memory word 0xDEADBEEF -> CPU_GNT in cycle 0, CPU_STALL = 0, CPU_RVALID in cycle 1 with 0xDEADBEEF, DMA_RVALID = 0.
- CPU and DMA both requesting continuously, STARVE_LIMIT = 8 -> CPU granted for 8 cycles, DMA granted in cycle 8 with CPU_STALL = 1 in that cycle, starve_cnt then back to 0.
- DMA_LOCK held with 6 queued DMA writes while CPU_REQ = 1 -> DMA granted 4 consecutive beats, CPU granted on the 5th cycle, then DMA resumes.
- Alternating grants: CPU load of 0x10 followed next cycle by DMA load of 0x20 -> CPU_RVALID in cycle 1 and DMA_RVALID in cycle 2, each with the correct word, never both high.
- Store sb by DMA to 0x203 with data 0xAB -> MEM_WRITE2 = 1, MEM_SIZE = 0, MEM_ADDR2 = 0x203, no RVALID.
- MEM_RST_N pulled low in the cycle after a granted CPU load -> CPU_RVALID stays 0, all outputs read 0 during reset, and arbitration resumes in IDLE after release.
